imem_boot_ctrl: RTL and testbench

//  Sequences the instruction memory (IM) of the single-cycle CPU: after reset it zero-fills IM,

---
 rtl/imem_boot_ctrl.sv | 100 ++++++++++
 tb/tb_imem_boot_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: zero-fills IM, loads a big-endian byte-stream program, then releases the CPU
module imem_boot_ctrl #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_stall,
  output logic              boot_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [1:0] {CLEAR, LOAD, FIN, RUN} state_t;
  localparam logic [ADDR_W:0] full_cnt = (ADDR_W+1)'(DEPTH);
  state_t state;
  logic [ADDR_W-1:0] clr_ptr, wr_ptr, addr_r;
  logic [1:0] byte_idx;
  logic [31:0] asm_word, next_word;
  logic accept;
  assign accept = ld_valid && ld_ready;
  assign next_word = asm_word | ({24'd0, ld_data} << {~byte_idx, 3'b000});
  assign im_addr = (state == RUN) ? pc[ADDR_W+1:2] : addr_r;
  assign cpu_stall = ~boot_done;
  // boot sequencer: clear sweep, byte assembly with one-cycle write latency, run/reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      clr_ptr <= '0;
      wr_ptr <= '0;
      addr_r <= '0;
      byte_idx <= '0;
      asm_word <= '0;
      im_we <= 1'b0;
      im_wdata <= '0;
      ld_ready <= 1'b0;
      boot_done <= 1'b0;
      load_err <= 1'b0;
      word_count <= '0;
    end else begin
      im_we <= 1'b0;
      case (state)
        CLEAR: begin
          im_we <= 1'b1;
          im_wdata <= '0;
          addr_r <= clr_ptr;
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) state <= LOAD;
        end
        LOAD: begin
          ld_ready <= !(accept && ld_last);
          if (accept) begin
            if (ld_last || &byte_idx) begin
              byte_idx <= '0;
              asm_word <= '0;
              if (word_count == full_cnt) begin
                load_err <= 1'b1;
              end else begin
                im_we <= 1'b1;
                addr_r <= wr_ptr;
                im_wdata <= next_word;
                wr_ptr <= wr_ptr + 1'b1;
                word_count <= word_count + 1'b1;
              end
            end else begin
              asm_word <= next_word;
              byte_idx <= byte_idx + 1'b1;
            end
            if (ld_last) state <= FIN;
          end
        end
        FIN: begin
          state <= RUN;
          boot_done <= 1'b1;
        end
        RUN: begin
          if (reload) begin
            state <= CLEAR;
            boot_done <= 1'b0;
            clr_ptr <= '0;
            wr_ptr <= '0;
            addr_r <= '0;
            byte_idx <= '0;
            asm_word <= '0;
            word_count <= '0;
            load_err <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: scoreboarded random-load bench for the IM boot controller
module tb_imem_boot_ctrl;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] pc = '0;
  logic ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic ld_last = 1'b0;
  logic reload = 1'b0;
  logic ld_ready, im_we, cpu_stall, boot_done, load_err;
  logic [7:0] im_addr;
  logic [31:0] im_wdata;
  logic [8:0] word_count;
  int checks = 0;
  int failures = 0;
  longint cyc = 0;
  longint last_we_cyc = 0;
  logic [39:0] exp_q[$];
  logic [7:0] bq[$];

  imem_boot_ctrl #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .reload(reload), .im_we(im_we),
    .im_addr(im_addr), .im_wdata(im_wdata), .cpu_stall(cpu_stall),
    .boot_done(boot_done), .load_err(load_err), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every IM write is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (rst_n) begin
      chk("stall_is_not_done", cpu_stall, !boot_done);
      if (im_we) begin
        chk("no_write_in_run", boot_done, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", im_addr, im_wdata);
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", im_addr, e[39:32]);
          chk("wr_data", im_wdata, e[31:0]);
        end
        last_we_cyc = cyc;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic push_clear();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({i[7:0], 32'h0});
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!ld_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("ld_ready_after_clear", ld_ready, 1'b1);
    chk("clear_writes_done", exp_q.size(), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int g = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    ld_valid = 1'b1;
    ld_data = b;
    ld_last = l;
    while (!ld_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("ld_ready_for_byte", ld_ready, 1'b1);
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last = 1'b0;
    if (l) chk("ld_ready_drops_after_last", ld_ready, 1'b0);
  endtask

  task automatic push_words(input int n);
    int nw;
    logic [31:0] w;
    nw = (n + 3) / 4;
    for (int i = 0; i < nw && i < DEPTH; i++) begin
      w = '0;
      for (int k = 0; k < 4; k++) if (4 * i + k < n) w[31 - 8 * k -: 8] = bq[4 * i + k];
      exp_q.push_back({i[7:0], w});
    end
  endtask

  task automatic do_load();
    int n, nw, g;
    n = bq.size();
    nw = (n + 3) / 4;
    push_words(n);
    for (int j = 0; j < n; j++) send_byte(bq[j], j == n - 1);
    g = 0;
    while (!boot_done && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("boot_done", boot_done, 1'b1);
    if (nw <= DEPTH) chk("boot_one_cycle_after_write", cyc - last_we_cyc, 1);
    chk("word_count", word_count, (nw > DEPTH) ? DEPTH : nw);
    chk("load_err", load_err, nw > DEPTH);
    chk("load_writes_done", exp_q.size(), 0);
    chk("run_no_write", im_we, 1'b0);
  endtask

  task automatic do_reload();
    push_clear();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_stall", cpu_stall, 1'b1);
    chk("reload_boot_done", boot_done, 1'b0);
    chk("reload_load_err", load_err, 1'b0);
    chk("reload_word_count", word_count, 0);
    wait_ready();
  endtask

  task automatic reset_checks();
    chk("rst_im_we", im_we, 1'b0);
    chk("rst_ld_ready", ld_ready, 1'b0);
    chk("rst_cpu_stall", cpu_stall, 1'b1);
    chk("rst_boot_done", boot_done, 1'b0);
    chk("rst_load_err", load_err, 1'b0);
    chk("rst_word_count", word_count, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_im_wdata", im_wdata, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 reset_checks();
    push_clear();
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready();
    bq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
    do_load();
    @(negedge clk);
    pc = 32'h0000_0404;
    #1 chk("pc_404", im_addr, 8'h01);
    pc = 32'h0000_0003;
    #1 chk("pc_003", im_addr, 8'h00);
    chk("pc_no_we", im_we, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] p;
      p = $urandom;
      pc = p;
      #1 chk("pc_rand", im_addr, (p >> 2) % DEPTH);
    end
    do_reload();
    bq = '{8'hAA, 8'hBB};
    do_load();
    for (int r = 0; r < 4; r++) begin
      do_reload();
      bq.delete();
      repeat ($urandom_range(1, 40)) bq.push_back(8'($urandom));
      do_load();
    end
    do_reload();
    bq.delete();
    repeat (1028) bq.push_back(8'($urandom));
    do_load();
    do_reload();
    bq.delete();
    repeat (6) bq.push_back(8'($urandom));
    push_words(4);
    for (int j = 0; j < 6; j++) begin
      send_byte(bq[j], 1'b0);
      if (j == 2) begin
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
      end
    end
    chk("partial_word_count", word_count, 1);
    chk("reload_ignored_in_load", ld_ready, 1'b1);
    chk("partial_writes_done", exp_q.size(), 0);
    #2 rst_n = 1'b0;
    #1 reset_checks();
    exp_q.delete();
    push_clear();
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready();
    bq = '{8'hAA, 8'hBB};
    do_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
